// File: rtl/stg4mo_mp_pkg.sv
// ============================================================================
//  Module   : stg4mo_mp_pkg
//  Purpose  : Shared widths, opcodes, memory-stage state encodings and
//             memory-op classifiers for the diad pipeline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package stg4mo_mp_pkg;

    localparam int SIZE_OPC    = 6;
    localparam int SIZE_TGT_GP = 4;
    localparam int SIZE_TGT_SR = 2;

    localparam logic [SIZE_OPC-1:0] OPC_NOP     = 6'h00;
    localparam logic [SIZE_OPC-1:0] OPC_R_ADD   = 6'h01;
    localparam logic [SIZE_OPC-1:0] OPC_R_SUB   = 6'h02;
    localparam logic [SIZE_OPC-1:0] OPC_R_LD    = 6'h10;
    localparam logic [SIZE_OPC-1:0] OPC_R_ST    = 6'h11;
    localparam logic [SIZE_OPC-1:0] OPC_I_STi   = 6'h12;
    localparam logic [SIZE_OPC-1:0] OPC_IS_STis = 6'h13;

    // Memory-stage FSM encoding, also consulted by the hazard unit.
    typedef enum logic [0:0] {
        MO_IDLE   = 1'b0,
        MO_ACCESS = 1'b1
    } mo_state_e;

    function automatic logic is_store_op(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_R_ST) || (opc == OPC_I_STi) || (opc == OPC_IS_STis);
    endfunction

    function automatic logic is_load_op(input logic [SIZE_OPC-1:0] opc);
        return (opc == OPC_R_LD);
    endfunction

    function automatic logic is_mem_op(input logic [SIZE_OPC-1:0] opc);
        return is_load_op(opc) || is_store_op(opc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/stg4mo_mp_mem_port_fanout.sv
// ============================================================================
//  Module   : stg4mo_mp_mem_port_fanout
//  Purpose  : Combinational steering of one held access onto N memory ports
//             and selection of the addressed port's ack/rdata.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stg4mo_mp_mem_port_fanout #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 24,
    parameter int N_MP   = 2,
    parameter int MP_W   = 1
) (
    input  logic                     i_active,
    input  logic [MP_W-1:0]          i_port,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [N_MP-1:0]          o_mem_req,
    output logic [N_MP-1:0]          o_mem_we,
    output logic [N_MP*ADDR_W-1:0]   o_mem_addr,
    output logic [N_MP*DATA_W-1:0]   o_mem_wdata,
    input  logic [N_MP-1:0]          i_mem_ack,
    input  logic [N_MP*DATA_W-1:0]   i_mem_rdata,
    output logic                     o_sel_ack,
    output logic [DATA_W-1:0]        o_sel_rdata
);

    // Non-selected ports see constant zeros, so they never glitch.
    for (genvar k = 0; k < N_MP; k++) begin : g_port
        logic w_hit;
        assign w_hit                              = i_active && (i_port == MP_W'(k));
        assign o_mem_req[k]                       = w_hit;
        assign o_mem_we[k]                        = w_hit & i_we;
        assign o_mem_addr[k*ADDR_W +: ADDR_W]     = w_hit ? i_addr  : '0;
        assign o_mem_wdata[k*DATA_W +: DATA_W]    = w_hit ? i_wdata : '0;
    end

    always_comb begin
        o_sel_ack   = 1'b0;
        o_sel_rdata = '0;
        for (int k = 0; k < N_MP; k++) begin
            if (o_mem_req[k]) begin
                o_sel_ack   = i_mem_ack[k];
                o_sel_rdata = i_mem_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/stg4mo_mp.sv
// ============================================================================
//  Module   : stg4mo_mp
//  Purpose  : Pipeline stage 4 (memory) with N req/ack ports, upstream stall,
//             timeout / bad-port abort and one-cycle pass-through.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module stg4mo_mp
    import stg4mo_mp_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 24,
    parameter int N_MP    = 2,
    parameter int MP_W    = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                     iw_clk,
    input  logic                     iw_rst,
    input  logic                     iw_valid,
    output logic                     ow_stall,
    input  logic [ADDR_W-1:0]        iw_pc,
    output logic [ADDR_W-1:0]        ow_pc,
    input  logic [DATA_W-1:0]        iw_instr,
    output logic [DATA_W-1:0]        ow_instr,
    input  logic [SIZE_OPC-1:0]      iw_opc,
    output logic [SIZE_OPC-1:0]      ow_opc,
    input  logic [SIZE_TGT_GP-1:0]   iw_tgt_gp,
    input  logic                     iw_tgt_gp_we,
    output logic [SIZE_TGT_GP-1:0]   ow_tgt_gp,
    output logic                     ow_tgt_gp_we,
    input  logic [SIZE_TGT_SR-1:0]   iw_tgt_sr,
    input  logic                     iw_tgt_sr_we,
    output logic [SIZE_TGT_SR-1:0]   ow_tgt_sr,
    output logic                     ow_tgt_sr_we,
    input  logic [MP_W-1:0]          iw_mem_mp,
    input  logic [ADDR_W-1:0]        iw_addr,
    input  logic [DATA_W-1:0]        iw_result,
    output logic                     ow_valid,
    output logic [DATA_W-1:0]        ow_result,
    output logic                     ow_fault,
    output logic [N_MP-1:0]          ow_mem_req,
    output logic [N_MP-1:0]          ow_mem_we,
    output logic [N_MP*ADDR_W-1:0]   ow_mem_addr,
    output logic [N_MP*DATA_W-1:0]   ow_mem_wdata,
    input  logic [N_MP-1:0]          iw_mem_ack,
    input  logic [N_MP*DATA_W-1:0]   iw_mem_rdata
);

    localparam logic [7:0] C_CNT_LAST = 8'(TIMEOUT - 1);

    mo_state_e r_state;
    mo_state_e w_state_nx;

    logic [ADDR_W-1:0]       r_h_pc;
    logic [DATA_W-1:0]       r_h_instr;
    logic [SIZE_OPC-1:0]     r_h_opc;
    logic [SIZE_TGT_GP-1:0]  r_h_tgt_gp;
    logic                    r_h_tgt_gp_we;
    logic [SIZE_TGT_SR-1:0]  r_h_tgt_sr;
    logic                    r_h_tgt_sr_we;
    logic [MP_W-1:0]         r_h_mp;
    logic [ADDR_W-1:0]       r_h_addr;
    logic [DATA_W-1:0]       r_h_result;
    logic [7:0]              r_cnt;

    logic                    w_is_mem;
    logic                    w_port_ok;
    logic                    w_pass;
    logic                    w_bad;
    logic                    w_capture;
    logic                    w_done;
    logic                    w_abort;
    logic                    w_sel_ack;
    logic [DATA_W-1:0]       w_sel_rdata;

    assign w_is_mem  = is_mem_op(iw_opc);
    assign w_port_ok = (32'(iw_mem_mp) < 32'(N_MP));

    stg4mo_mp_mem_port_fanout #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_MP   (N_MP),
        .MP_W   (MP_W)
    ) u_fanout (
        .i_active    (r_state == MO_ACCESS),
        .i_port      (r_h_mp),
        .i_we        (is_store_op(r_h_opc)),
        .i_addr      (r_h_addr),
        .i_wdata     (r_h_result),
        .o_mem_req   (ow_mem_req),
        .o_mem_we    (ow_mem_we),
        .o_mem_addr  (ow_mem_addr),
        .o_mem_wdata (ow_mem_wdata),
        .i_mem_ack   (iw_mem_ack),
        .i_mem_rdata (iw_mem_rdata),
        .o_sel_ack   (w_sel_ack),
        .o_sel_rdata (w_sel_rdata)
    );

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) r_state <= MO_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pass     = 1'b0;
        w_bad      = 1'b0;
        w_capture  = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            MO_IDLE: begin
                if (iw_valid) begin
                    if (!w_is_mem) begin
                        w_pass = 1'b1;
                    end else if (w_port_ok) begin
                        w_capture  = 1'b1;
                        w_state_nx = MO_ACCESS;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            MO_ACCESS: begin
                if (w_sel_ack) begin
                    w_done     = 1'b1;
                    w_state_nx = MO_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_abort    = 1'b1;
                    w_state_nx = MO_IDLE;
                end
            end
            default: w_state_nx = MO_IDLE;
        endcase
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            ow_valid      <= 1'b0;
            ow_fault      <= 1'b0;
            ow_stall      <= 1'b0;
            ow_pc         <= '0;
            ow_instr      <= '0;
            ow_opc        <= '0;
            ow_tgt_gp     <= '0;
            ow_tgt_gp_we  <= 1'b0;
            ow_tgt_sr     <= '0;
            ow_tgt_sr_we  <= 1'b0;
            ow_result     <= '0;
            r_h_pc        <= '0;
            r_h_instr     <= '0;
            r_h_opc       <= '0;
            r_h_tgt_gp    <= '0;
            r_h_tgt_gp_we <= 1'b0;
            r_h_tgt_sr    <= '0;
            r_h_tgt_sr_we <= 1'b0;
            r_h_mp        <= '0;
            r_h_addr      <= '0;
            r_h_result    <= '0;
            r_cnt         <= '0;
        end else begin
            ow_valid <= 1'b0;

            // Bad-port memory ops retire immediately as faults with no side effects.
            if (w_pass || w_bad) begin
                ow_pc        <= iw_pc;
                ow_instr     <= iw_instr;
                ow_opc       <= iw_opc;
                ow_tgt_gp    <= iw_tgt_gp;
                ow_tgt_gp_we <= iw_tgt_gp_we & ~w_bad;
                ow_tgt_sr    <= iw_tgt_sr;
                ow_tgt_sr_we <= iw_tgt_sr_we & ~w_bad;
                ow_result    <= iw_result;
                ow_valid     <= 1'b1;
                ow_fault     <= w_bad;
            end

            if (w_capture) begin
                r_h_pc        <= iw_pc;
                r_h_instr     <= iw_instr;
                r_h_opc       <= iw_opc;
                r_h_tgt_gp    <= iw_tgt_gp;
                r_h_tgt_gp_we <= iw_tgt_gp_we;
                r_h_tgt_sr    <= iw_tgt_sr;
                r_h_tgt_sr_we <= iw_tgt_sr_we;
                r_h_mp        <= iw_mem_mp;
                r_h_addr      <= iw_addr;
                r_h_result    <= iw_result;
                r_cnt         <= '0;
                ow_stall      <= 1'b1;
            end

            if ((r_state == MO_ACCESS) && !w_done && !w_abort) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_done || w_abort) begin
                ow_pc        <= r_h_pc;
                ow_instr     <= r_h_instr;
                ow_opc       <= r_h_opc;
                ow_tgt_gp    <= r_h_tgt_gp;
                ow_tgt_gp_we <= r_h_tgt_gp_we & ~w_abort;
                ow_tgt_sr    <= r_h_tgt_sr;
                ow_tgt_sr_we <= r_h_tgt_sr_we & ~w_abort;
                ow_result    <= (w_done && is_load_op(r_h_opc)) ? w_sel_rdata : r_h_result;
                ow_valid     <= 1'b1;
                ow_fault     <= w_abort;
                ow_stall     <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
